rx_decim_chain: RTL and testbench

Parametrised multi-channel I/Q CIC decimation chain. Generalised successor of the single-pair receive decimator: channel count, sample widths and CIC order are parameters, and the rate, output shift and rounding are runtime-programmable over the serial bus. Sits between the per-channel NCO/CORDIC outputs and the RX FIFO packer. One shared rate counter drives all channels, so their outputs stay sample-aligned.

---
 rtl/rx_decim_pkg.sv | 18 +
 rtl/cic_decim_rail.sv | 107 ++++++++++
 rtl/rx_decim_chain.sv | 128 ++++++++++++
 tb/tb_rx_decim_chain.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_decim_pkg.sv
// Shared constants and helpers for the multi-channel I/Q CIC decimation chain.
// Optional saturation is selected with the RX_DECIM_SAT_EN macro in the files that import this package.
package rx_decim_pkg;

    localparam int RATE_LSB    = 0;
    localparam int SHIFT_LSB   = 8;
    localparam int OVF_CLR_BIT = 31;

    localparam int MAX_RATE = 256;
    localparam int RATE_W   = $clog2(MAX_RATE);
    localparam int SHIFT_W  = 6;

    // Worst-case CIC growth is NSTG*log2(MAX_RATE) bits on top of the input width.
    function automatic int calc_aw(input int iw, input int nstg);
        return iw + RATE_W * nstg;
    endfunction

endpackage

// File: rtl/cic_decim_rail.sv
// One CIC decimation rail: integrators, combs, round-half-up shift and output register.
// With RX_DECIM_SAT_EN defined the result is clamped and clip reports it; otherwise it wraps.
module cic_decim_rail
    import rx_decim_pkg::*;
#(
    parameter int IW   = 16,
    parameter int OW   = 16,
    parameter int NSTG = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               acc,
    input  logic               fire,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [IW-1:0]      din,
    output logic [OW-1:0]      dout,
    output logic               clip
);

    localparam int AW = calc_aw(IW, NSTG);

    logic [AW-1:0] integ_q [NSTG];
    logic [AW-1:0] integ_d [NSTG];
    logic [AW-1:0] dly_q   [NSTG];
    logic [AW-1:0] comb_y  [NSTG];
    logic [AW-1:0] rnd;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] v;
    logic [OW-1:0] res;
    logic          clip_raw;

    // Integrators chain within one sample, so every stage sees the current input.
    always_comb begin
        integ_d[0] = integ_q[0] + {{(AW-IW){din[IW-1]}}, din};
        for (int k = 1; k < NSTG; k++) begin
            integ_d[k] = integ_q[k] + integ_d[k-1];
        end
        comb_y[0] = integ_q[NSTG-1] - dly_q[0];
        for (int k = 1; k < NSTG; k++) begin
            comb_y[k] = comb_y[k-1] - dly_q[k];
        end
    end

    always_comb begin
        rnd = '0;
        if (shift != '0) begin
            rnd = AW'(1) << (shift - 1'b1);
        end
        sum = comb_y[NSTG-1] + rnd;
        v   = sum >>> shift;
`ifdef RX_DECIM_SAT_EN
        if ((&v[AW-1:OW-1]) || !(|v[AW-1:OW-1])) begin
            res      = v[OW-1:0];
            clip_raw = 1'b0;
        end else begin
            res      = v[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
            clip_raw = 1'b1;
        end
`else
        res      = v[OW-1:0];
        clip_raw = 1'b0;
`endif
    end

`ifndef RX_DECIM_SAT_EN
    logic unused_v;
    assign unused_v = ^v[AW-1:OW];
`endif

    assign clip = fire & clip_raw;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSTG; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
        end else if (clr) begin
            for (int k = 0; k < NSTG; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
        end else begin
            if (acc) begin
                for (int k = 0; k < NSTG; k++) begin
                    integ_q[k] <= integ_d[k];
                end
            end
            if (fire) begin
                dly_q[0] <= integ_q[NSTG-1];
                for (int k = 1; k < NSTG; k++) begin
                    dly_q[k] <= comb_y[k-1];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
        end else if (fire) begin
            dout <= res;
        end
    end

endmodule

// File: rtl/rx_decim_chain.sv
// Multi-channel I/Q CIC decimator: serial rate/shift register, shared phase counter, 2*NCH rails.
// Define RX_DECIM_SAT_EN for clamping outputs and a sticky overflow flag; otherwise overflow is 0.
module rx_decim_chain
    import rx_decim_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int IW       = 16,
    parameter int OW       = 16,
    parameter int NSTG     = 4,
    parameter int RATEADDR = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [6:0]        serial_addr,
    input  logic [31:0]       serial_data,
    input  logic              serial_strobe,
    input  logic              strobe_in,
    input  logic [NCH*IW-1:0] i_in,
    input  logic [NCH*IW-1:0] q_in,
    output logic              strobe_out,
    output logic [NCH*OW-1:0] i_out,
    output logic [NCH*OW-1:0] q_out,
    output logic              overflow
);

    // Strobe semantics: strobe_in marks one valid input sample per clock (no back-pressure);
    // strobe_out is a one-clock pulse in the same cycle the new i_out/q_out values appear.
    logic               wr;
    logic               acc;
    logic               clr;
    logic               fire;
    logic               dec_stb;
    logic [RATE_W-1:0]  rate;
    logic [RATE_W-1:0]  phase;
    logic [SHIFT_W-1:0] shift;
    logic [2*NCH-1:0]   clip;

    // A register write resyncs everything and takes priority over a coincident sample.
    assign wr   = serial_strobe && (serial_addr == 7'(RATEADDR));
    assign acc  = strobe_in && enable && !wr;
    assign clr  = wr || !enable;
    assign fire = dec_stb && enable && !wr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rate  <= '0;
            shift <= '0;
        end else if (wr) begin
            rate  <= serial_data[RATE_LSB +: RATE_W];
            shift <= serial_data[SHIFT_LSB +: SHIFT_W];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= '0;
            dec_stb <= 1'b0;
        end else if (clr) begin
            phase   <= '0;
            dec_stb <= 1'b0;
        end else if (acc) begin
            if (phase == rate) begin
                phase   <= '0;
                dec_stb <= 1'b1;
            end else begin
                phase   <= phase + 1'b1;
                dec_stb <= 1'b0;
            end
        end else begin
            dec_stb <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe_out <= 1'b0;
        end else begin
            strobe_out <= fire;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        cic_decim_rail #(.IW(IW), .OW(OW), .NSTG(NSTG)) u_i (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (clr),
            .acc     (acc),
            .fire    (fire),
            .shift   (shift),
            .din     (i_in[c*IW +: IW]),
            .dout    (i_out[c*OW +: OW]),
            .clip    (clip[2*c])
        );
        cic_decim_rail #(.IW(IW), .OW(OW), .NSTG(NSTG)) u_q (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (clr),
            .acc     (acc),
            .fire    (fire),
            .shift   (shift),
            .din     (q_in[c*IW +: IW]),
            .dout    (q_out[c*OW +: OW]),
            .clip    (clip[2*c+1])
        );
    end

`ifdef RX_DECIM_SAT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr && serial_data[OVF_CLR_BIT]) begin
            overflow <= 1'b0;
        end else if (|clip) begin
            overflow <= 1'b1;
        end
    end

    logic unused_data;
    assign unused_data = ^serial_data[OVF_CLR_BIT-1:SHIFT_LSB+SHIFT_W];
`else
    assign overflow = 1'b0;

    logic unused_data;
    assign unused_data = ^{serial_data[OVF_CLR_BIT:SHIFT_LSB+SHIFT_W], clip};
`endif

endmodule

// File: tb/tb_rx_decim_chain.sv
// Scoreboard bench for rx_decim_chain: directed vectors, expected outputs queued at stimulus time.
// Honours RX_DECIM_SAT_EN for the saturation/overflow expectations.
module tb_rx_decim_chain;

    localparam int NCH = 2;
    localparam int IW  = 16;
    localparam int OW  = 16;
    localparam int EW  = 32 + 1 + 4*OW;

`ifdef RX_DECIM_SAT_EN
    localparam logic [15:0] EXP_R15 = 16'h7fff;
    localparam logic        EXP_OVF = 1'b1;
`else
    localparam logic [15:0] EXP_R15 = 16'he800;
    localparam logic        EXP_OVF = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic              enable        = 1'b0;
    logic [6:0]        serial_addr   = '0;
    logic [31:0]       serial_data   = '0;
    logic              serial_strobe = 1'b0;
    logic              strobe_in     = 1'b0;
    logic [15:0]       in_i0 = '0, in_q0 = '0, in_i1 = '0, in_q1 = '0;
    logic [NCH*IW-1:0] i_in, q_in;
    logic              strobe_out;
    logic [NCH*OW-1:0] i_out, q_out;
    logic              overflow;

    assign i_in = {in_i1, in_i0};
    assign q_in = {in_q1, in_q0};

    rx_decim_chain #(.NCH(NCH), .IW(IW), .OW(OW), .NSTG(4), .RATEADDR(0)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .strobe_in     (strobe_in),
        .i_in          (i_in),
        .q_in          (q_in),
        .strobe_out    (strobe_out),
        .i_out         (i_out),
        .q_out         (q_out),
        .overflow      (overflow)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    int d_mod = 1;
    int ph    = 0;
    int nout  = 0;
    int skip  = 0;
    logic [15:0] ei0 = '0, eq0 = '0, ei1 = '0, eq1 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
        in_i0 = a; in_q0 = b; in_i1 = c; in_q1 = d;
    endtask

    task automatic set_exp(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        ei0 = a; eq0 = b; ei1 = c; eq1 = d;
    endtask

    // An output due next cycle is cancelled by a resync or enable drop now.
    task automatic cancel_pending();
        logic [EW-1:0] t;
        if (exp_q.size() != 0) begin
            t = exp_q[$];
            if (t[EW-1 -: 32] == 32'(cyc + 1)) void'(exp_q.pop_back());
        end
    endtask

    task automatic step(input logic stb);
        strobe_in = stb;
        if (stb && enable && !serial_strobe) begin
            ph++;
            if (ph == d_mod) begin
                ph = 0;
                exp_q.push_back({32'(cyc + 2), (nout >= skip), eq1, ei1, eq0, ei0});
                nout++;
            end
        end
        @(negedge clock);
    endtask

    task automatic wr_reg(input logic [31:0] d, input logic stb);
        cancel_pending();
        serial_strobe = 1'b1;
        serial_addr   = 7'd0;
        serial_data   = d;
        strobe_in     = stb;
        d_mod = int'(d[7:0]) + 1;
        ph    = 0;
        nout  = 0;
        @(negedge clock);
        serial_strobe = 1'b0;
        strobe_in     = 1'b0;
    endtask

    task automatic set_en(input logic e);
        if (!e) begin
            cancel_pending();
            ph   = 0;
            nout = 0;
        end
        enable    = e;
        strobe_in = 1'b0;
        @(negedge clock);
    endtask

    task automatic drain();
        strobe_in = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (strobe_out === 1'b1) begin
                chk("stb_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("stb_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
                    if (e[4*OW])
                        chk("data", {q_out[31:16], i_out[31:16], q_out[15:0], i_out[15:0]},
                            e[4*OW-1:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_i_out", 64'(i_out), 64'd0);
        chk("rst_q_out", 64'(q_out), 64'd0);
        chk("rst_stb", 64'(strobe_out), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Default pass-through, continuous strobes, extreme values.
        d_mod = 1; skip = 0;
        set_in(16'd1234, -16'sd1234, 16'h7fff, 16'h8000);
        set_exp(16'd1234, -16'sd1234, 16'h7fff, 16'h8000);
        repeat (10) step(1'b1);
        drain();

        // D=4, S=8, DC 1000.
        wr_reg(32'h0000_0803, 1'b0);
        skip = 4;
        set_in(16'd1000, 16'd1000, 16'd1000, 16'd1000);
        set_exp(16'd1000, 16'd1000, 16'd1000, 16'd1000);
        repeat (24) step(1'b1);
        drain();

        // D=2, S=5: +0.5 rounds up to 1, -0.5 rounds up to 0.
        wr_reg(32'h0000_0501, 1'b0);
        set_in(16'd1, 16'hffff, 16'd1, 16'hffff);
        set_exp(16'd1, 16'd0, 16'd1, 16'd0);
        repeat (12) step(1'b1);
        drain();

        // D=16, S=8, DC 1000: saturates or wraps.
        wr_reg(32'h0000_080f, 1'b0);
        set_in(16'd1000, 16'd1000, 16'd1000, 16'd1000);
        set_exp(EXP_R15, EXP_R15, EXP_R15, EXP_R15);
        repeat (96) step(1'b1);
        drain();
        chk("ovf_set", 64'(overflow), 64'(EXP_OVF));
        wr_reg(32'h8000_080f, 1'b0);
        chk("ovf_clr", 64'(overflow), 64'd0);

        // D=5, strobe every 3rd clock: output every 15 clocks, 2 after each 5th strobe.
        wr_reg(32'h0000_0804, 1'b0);
        set_exp(16'd2441, 16'd2441, 16'd2441, 16'd2441);
        repeat (30) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
        end
        drain();

        // Resync, enable drop and cancellation; timing only.
        wr_reg(32'h0000_0803, 1'b0);
        skip = 1000;
        repeat (2) step(1'b1);
        wr_reg(32'h0000_0803, 1'b1);
        repeat (4) step(1'b1);
        drain();
        repeat (2) step(1'b1);
        set_en(1'b0);
        step(1'b1);
        set_en(1'b1);
        repeat (4) step(1'b1);
        drain();
        repeat (4) step(1'b1);
        wr_reg(32'h0000_0803, 1'b0);
        repeat (3) step(1'b0);
        repeat (4) step(1'b1);
        drain();
        repeat (4) step(1'b1);
        set_en(1'b0);
        set_en(1'b1);
        repeat (3) step(1'b0);
        chk("cancel_idle", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while strobe_out is high.
        repeat (4) step(1'b1);
        step(1'b0);
        chk("pre_rst_stb", 64'(strobe_out), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_i_out", 64'(i_out), 64'd0);
        chk("arst_q_out", 64'(q_out), 64'd0);
        chk("arst_stb", 64'(strobe_out), 64'd0);
        chk("arst_ovf", 64'(overflow), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        d_mod = 1; ph = 0; nout = 0; skip = 0;
        set_in(-16'sd7, 16'd300, 16'd5, -16'sd300);
        set_exp(-16'sd7, 16'd300, 16'd5, -16'sd300);
        step(1'b1);
        drain();
        wr_reg(32'h0000_0803, 1'b0);
        skip = 4;
        repeat (4) step(1'b1);
        drain();
        repeat (5) @(negedge clock);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
